// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the fetch FSM encoding plus PC step/reset defaults and the alignment mask.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    TRAP = 3'd4
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam int unsigned DEF_INST_BYTES = 4;
  localparam logic [1:0]  MISALIGN_MASK  = 2'b11;

endpackage

// File: rtl/fetch_sequencer.sv
// PC owner issuing one fetch at a time: REQ -> WAIT -> HOLD, min 3 cycles per instruction.
// Stalls in REQ on !imem_req_ready and in HOLD on !inst_ready; taken redirects squash wrong-path work.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int unsigned INST_BYTES = DEF_INST_BYTES
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic        branch,
  input  logic [31:0] redirect_target,
  output logic        misalign,
  output logic [31:0] misalign_addr
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_addr;
  logic [31:0]  r_inst_data;
  logic [31:0]  r_inst_pc;
  logic         r_kill;
  logic         r_trap_pend;
  logic         r_misalign;
  logic [31:0]  r_misalign_addr;

  logic         w_taken;
  logic         w_active;
  logic         w_target_misal;
  logic         w_redir;
  logic         w_trap;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_pc_inc;

  assign w_taken        = redirect_valid && branch;
  // Once a trap is pending or taken, further resolutions are meaningless and ignored.
  assign w_active       = w_taken && (r_state != TRAP) && !r_trap_pend;
  assign w_target_misal = (redirect_target[1:0] & MISALIGN_MASK) != 2'b00;
  assign w_redir        = w_active && !w_target_misal;
  assign w_trap         = w_active && w_target_misal;
  assign w_pc_nxt       = w_redir ? redirect_target : r_pc;
  assign w_pc_inc       = r_pc + 32'(INST_BYTES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_pc            <= RESET_PC;
      r_addr          <= RESET_PC;
      r_inst_data     <= '0;
      r_inst_pc       <= '0;
      r_kill          <= 1'b0;
      r_trap_pend     <= 1'b0;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      if (w_redir) r_pc <= redirect_target;
      if (w_trap) begin
        r_misalign      <= 1'b1;
        r_misalign_addr <= redirect_target;
      end
      case (r_state)
        IDLE: begin
          if (w_trap) begin
            r_state <= TRAP;
          end else begin
            r_state <= REQ;
            r_addr  <= w_pc_nxt;
          end
        end
        REQ: begin
          // The address stays put until accepted; the stale request is squashed later.
          if (w_redir) r_kill <= 1'b1;
          if (w_trap) r_trap_pend <= 1'b1;
          if (imem_req_ready) r_state <= WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            r_kill <= 1'b0;
            if (r_trap_pend || w_trap) begin
              r_state <= TRAP;
            end else if (r_kill || w_redir) begin
              r_state <= REQ;
              r_addr  <= w_pc_nxt;
            end else begin
              r_state     <= HOLD;
              r_inst_data <= imem_rsp_data;
              r_inst_pc   <= r_addr;
            end
          end else begin
            if (w_redir) r_kill <= 1'b1;
            if (w_trap) r_trap_pend <= 1'b1;
          end
        end
        HOLD: begin
          if (w_trap) begin
            r_state <= TRAP;
          end else if (w_redir) begin
            r_state <= REQ;
            r_addr  <= redirect_target;
          end else if (inst_ready) begin
            r_state <= REQ;
            r_pc    <= w_pc_inc;
            r_addr  <= w_pc_inc;
          end
        end
        TRAP:    r_state <= TRAP;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_req_valid = (r_state == REQ);
  assign imem_addr      = r_addr;
  // Gate on the raw redirect so a wrong-path instruction never transfers in the redirect cycle.
  assign inst_valid     = (r_state == HOLD) && !w_taken;
  assign inst_data      = r_inst_data;
  assign inst_pc        = r_inst_pc;
  assign misalign       = r_misalign;
  assign misalign_addr  = r_misalign_addr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scenario bench for fetch_sequencer: memory model, request/instruction scoreboards.
// Memory returns the bitwise inverse of the fetch address after a configurable latency.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic        branch;
  logic [31:0] redirect_target;
  logic        misalign;
  logic [31:0] misalign_addr;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .INST_BYTES(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .branch          (branch),
    .redirect_target (redirect_target),
    .misalign        (misalign),
    .misalign_addr   (misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  int          n_deliv;
  int          cyc;
  int          lat;
  logic [31:0] exp_req[$];
  logic [31:0] exp_inst[$];
  logic [31:0] pq_addr[$];
  int          pq_due[$];

  // One clock: score handshakes at the falling edge, then advance the memory model.
  task automatic tick();
    logic        acc;
    logic [31:0] acc_addr;
    logic [31:0] e;
    acc      = 1'b0;
    acc_addr = '0;
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      n_chk++;
      if (exp_req.size() == 0) begin
        n_fail++;
        $display("FAIL req_unexpected: got addr %h, required no request", imem_addr);
      end else begin
        e = exp_req.pop_front();
        if (imem_addr !== e) begin
          n_fail++;
          $display("FAIL req_addr: got %h, required %h", imem_addr, e);
        end
      end
      acc      = 1'b1;
      acc_addr = imem_addr;
    end
    if (inst_valid && inst_ready) begin
      n_chk++;
      n_deliv++;
      if (exp_inst.size() == 0) begin
        n_fail++;
        $display("FAIL inst_unexpected: got pc %h data %h, required no transfer", inst_pc, inst_data);
      end else begin
        e = exp_inst.pop_front();
        if (inst_pc !== e || inst_data !== ~e) begin
          n_fail++;
          $display("FAIL inst_xfer: got pc %h data %h, required pc %h data %h", inst_pc, inst_data, e, ~e);
        end
      end
    end
    if (imem_rsp_valid && pq_addr.size() > 0) begin
      pq_addr.delete(0);
      pq_due.delete(0);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      pq_addr.push_back(acc_addr);
      pq_due.push_back(cyc + lat - 1);
    end
    if (pq_addr.size() > 0 && pq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~pq_addr[0];
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    imem_req_ready  = 1'b1;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = '0;
    inst_ready      = 1'b1;
    redirect_valid  = 1'b0;
    branch          = 1'b0;
    redirect_target = '0;
    lat             = 1;
    exp_req.delete();
    exp_inst.delete();
    pq_addr.delete();
    pq_due.delete();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic run_deliv(input int n, input int bound, input string name);
    int target;
    int k;
    target = n_deliv + n;
    k      = 0;
    while (n_deliv < target && k < bound) begin
      tick();
      k++;
    end
    n_chk++;
    if (n_deliv < target) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d transfers, required %0d", name, n - (target - n_deliv), n);
    end
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (!imem_req_valid && k < 20) begin
      tick();
      k++;
    end
    n_chk++;
    if (!imem_req_valid) begin
      n_fail++;
      $display("FAIL %s_req_timeout: got imem_req_valid 0, required 1", name);
    end
  endtask

  task automatic wait_inst(input string name);
    int k;
    k = 0;
    while (!inst_valid && k < 20) begin
      tick();
      k++;
    end
    n_chk++;
    if (!inst_valid) begin
      n_fail++;
      $display("FAIL %s_inst_timeout: got inst_valid 0, required 1", name);
    end
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({imem_req_valid, inst_valid, misalign} !== 3'b000 || imem_addr !== 32'h0 ||
        inst_data !== 32'h0 || inst_pc !== 32'h0 || misalign_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req %b inst %b mis %b addr %h data %h pc %h maddr %h, required all zero",
               imem_req_valid, inst_valid, misalign, imem_addr, inst_data, inst_pc, misalign_addr);
    end
    tick();
    reset_n = 1'b1;
    #1;
    n_chk++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got imem_req_valid %b, required 0", imem_req_valid);
    end
    exp_req.push_back(32'h0);
    tick();
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_req: got valid %b addr %h, required 1 and 00000000", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(32'(i * 4));
      exp_inst.push_back(32'(i * 4));
    end
    exp_req.push_back(32'hC);
    run_deliv(3, 40, "seq");
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC || misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_next: got valid %b addr %h misalign %b, required 1 0000000c 0",
               imem_req_valid, imem_addr, misalign);
    end
  endtask

  task automatic test_hold_stall();
    do_reset();
    inst_ready = 1'b0;
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_inst.push_back(32'h0);
    exp_inst.push_back(32'h4);
    wait_inst("stall");
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (inst_valid !== 1'b1 || inst_data !== 32'hFFFF_FFFF || imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: got valid %b data %h req %b, required 1 ffffffff 0",
                 inst_valid, inst_data, imem_req_valid);
      end
      tick();
    end
    inst_ready = 1'b1;
    run_deliv(1, 5, "stall_release");
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL stall_advance: got valid %b addr %h, required 1 00000004", imem_req_valid, imem_addr);
    end
    run_deliv(1, 20, "stall_next");
  endtask

  task automatic test_wait_redirect();
    do_reset();
    lat = 2;
    exp_req.push_back(32'h0);
    wait_req("wait_redir");
    tick();
    redirect_valid  = 1'b1;
    branch          = 1'b1;
    redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    branch         = 1'b0;
    exp_req.push_back(32'h100);
    exp_inst.push_back(32'h100);
    tick();
    n_chk++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL wait_redir_refetch: got inst_valid %b req %b addr %h, required 0 1 00000100",
               inst_valid, imem_req_valid, imem_addr);
    end
    run_deliv(1, 30, "wait_redir");
  endtask

  task automatic test_req_stall_redirect();
    do_reset();
    imem_req_ready = 1'b0;
    wait_req("req_redir");
    redirect_valid  = 1'b1;
    branch          = 1'b1;
    redirect_target = 32'h240;
    tick();
    redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    branch         = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
        n_fail++;
        $display("FAIL req_redir_hold: got valid %b addr %h, required 1 00000000", imem_req_valid, imem_addr);
      end
      tick();
    end
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h200);
    exp_inst.push_back(32'h200);
    imem_req_ready = 1'b1;
    run_deliv(1, 30, "req_redir");
  endtask

  task automatic test_not_taken();
    do_reset();
    redirect_valid  = 1'b1;
    branch          = 1'b0;
    redirect_target = 32'h300;
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(32'(i * 4));
      exp_inst.push_back(32'(i * 4));
    end
    run_deliv(4, 60, "not_taken");
    redirect_valid = 1'b0;
  endtask

  task automatic test_redirect_wrap();
    do_reset();
    inst_ready = 1'b0;
    exp_req.push_back(32'h0);
    wait_inst("wrap");
    redirect_valid  = 1'b1;
    branch          = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    inst_ready      = 1'b1;
    #1;
    n_chk++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_gate: got inst_valid %b, required 0", inst_valid);
    end
    tick();
    redirect_valid = 1'b0;
    branch         = 1'b0;
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0);
    exp_inst.push_back(32'hFFFF_FFFC);
    exp_inst.push_back(32'h0);
    run_deliv(2, 40, "wrap");
  endtask

  task automatic test_misalign_hold();
    do_reset();
    inst_ready = 1'b0;
    exp_req.push_back(32'h0);
    wait_inst("mis");
    redirect_valid  = 1'b1;
    branch          = 1'b1;
    redirect_target = 32'h102;
    inst_ready      = 1'b1;
    #1;
    n_chk++;
    if (inst_valid !== 1'b0 || misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_gate: got inst_valid %b misalign %b, required 0 0", inst_valid, misalign);
    end
    tick();
    redirect_valid = 1'b0;
    branch         = 1'b0;
    n_chk++;
    if (misalign !== 1'b1 || misalign_addr !== 32'h102 || imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_flag: got misalign %b addr %h req %b, required 1 00000102 0",
               misalign, misalign_addr, imem_req_valid);
    end
    repeat (10) tick();
    n_chk++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || misalign !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_sticky: got req %b inst %b misalign %b, required 0 0 1",
               imem_req_valid, inst_valid, misalign);
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({imem_req_valid, inst_valid, misalign} !== 3'b000 || imem_addr !== 32'h0 ||
        inst_data !== 32'h0 || inst_pc !== 32'h0 || misalign_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL mis_reset: got req %b inst %b mis %b addr %h data %h pc %h maddr %h, required all zero",
               imem_req_valid, inst_valid, misalign, imem_addr, inst_data, inst_pc, misalign_addr);
    end
  endtask

  task automatic test_misalign_pending();
    int seen;
    do_reset();
    lat = 3;
    exp_req.push_back(32'h0);
    wait_req("mis_pend");
    tick();
    redirect_valid  = 1'b1;
    branch          = 1'b1;
    redirect_target = 32'h206;
    tick();
    redirect_target = 32'h400;
    tick();
    redirect_valid = 1'b0;
    branch         = 1'b0;
    n_chk++;
    if (misalign !== 1'b1 || misalign_addr !== 32'h206) begin
      n_fail++;
      $display("FAIL mis_pend_flag: got misalign %b addr %h, required 1 00000206", misalign, misalign_addr);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (inst_valid || imem_req_valid) seen++;
      tick();
    end
    n_chk++;
    if (seen != 0 || pq_addr.size() != 0) begin
      n_fail++;
      $display("FAIL mis_pend_quiet: got %0d active cycles, %0d responses left, required 0 and 0",
               seen, pq_addr.size());
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    n_deliv = 0;
    cyc     = 0;
    lat     = 1;
    reset_n = 1'b0;
    test_reset();
    test_sequential();
    test_hold_stall();
    test_wait_redirect();
    test_req_stall_redirect();
    test_not_taken();
    test_redirect_wrap();
    test_misalign_hold();
    test_misalign_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the program counter and issues instruction fetches on a valid/ready request, response-valid memory interface. It accepts taken/not-taken branch resolutions from the execute-stage comparator and redirects the PC accordingly. Wrong-path fetches are squashed. The block presents one instruction at a time to decode through a valid/ready handshake and traps on misaligned branch targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
INST_BYTES, 4, PC increment per sequential instruction.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  fetch address; stable while imem_req_valid && !imem_req_ready
imem_rsp_valid  in  1  fetch response valid; exactly one per accepted request, at least 1 cycle after acceptance
imem_rsp_data  in  32  fetched instruction word
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_data  out  32  instruction word
inst_pc  out  32  PC of inst_data
redirect_valid  in  1  branch/jump resolved this cycle
branch  in  1  resolution outcome: 1 = taken, 0 = not taken
redirect_target  in  32  target address, used when taken
misalign  out  1  sticky trap flag
misalign_addr  out  32  offending target

Behaviour:
- Reset values (async): state IDLE, pc = RESET_PC, imem_addr = RESET_PC, imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0, kill = 0, trap_pend = 0, misalign = 0, misalign_addr = 0.
- States and transitions:
  - IDLE -> REQ unconditionally. The first request is visible in the cycle after reset release.
  - REQ: imem_req_valid = 1 and imem_addr = pc. On imem_req_ready -> WAIT.
  - WAIT: on imem_rsp_valid, if kill or trap_pend the response is discarded. Otherwise it is captured into inst_data and inst_pc = imem_addr -> HOLD.
  - HOLD: inst_valid asserted. On inst_valid && inst_ready -> pc += INST_BYTES (mod 2^32, wraps) -> REQ.
  - TRAP: absorbing until reset. No requests issued, inst_valid = 0, imem_rsp_valid ignored.
- A taken redirect is redirect_valid && branch. Not-taken redirects (branch = 0) have no effect.
- Aligned taken redirect:
  - pc <= redirect_target in every state except TRAP.
  - REQ, not accepted this cycle: imem_addr is held (handshake stability). Set kill. The request completes, its response is discarded, then REQ issues the target.
  - REQ, accepted the same cycle: go to WAIT with kill = 1.
  - WAIT, no response: set kill.
  - WAIT, response the same cycle: discard the response -> REQ.
  - HOLD: the buffer is dropped -> REQ.
  - Multiple redirects before the kill clears: the latest target wins.
- inst_valid = (state == HOLD) && !(taken redirect). This combinational gate guarantees no wrong-path transfer in a redirect cycle.
- kill clears on the discarded response.
- Misaligned taken redirect (redirect_target[1:0] != 0):
  - Next cycle: misalign = 1 and misalign_addr = target, both sticky.
  - No new request is issued. Any accepted-or-pending request completes its handshake; its response is discarded (trap_pend).
  - From IDLE/HOLD, or once no request is outstanding -> TRAP.
- Redirects arriving in TRAP or with trap_pend set are ignored.
- Reset mid-operation: all state returns to reset values immediately. A response to a pre-reset request is the memory's responsibility and must not occur.

Decomposition:
- Shared package: fetch state enum (IDLE, REQ, WAIT, HOLD, TRAP), INST_BYTES, the RESET_PC default, and the misalignment mask constant 2'b11.
- No sub-module required. The redirect/kill/trap_pend logic stays in one always block with the state register; the PC incrementer is inline.

Test Plan:
- Reset release with RESET_PC = 0, ready = 1, 1-cycle response, inst_ready = 1 -> imem_addr sequence 0x0, 0x4, 0x8; inst_pc matches; misalign = 0.
- inst_ready held 0 for 5 cycles in HOLD -> inst_valid stays 1, inst_data stable, no new request; release -> pc advances by 4.
- In WAIT, taken redirect to 0x100 one cycle before response -> response discarded, inst_valid never 1 for it, next imem_addr = 0x100.
- In REQ with imem_req_ready = 0, taken redirect to 0x200 -> imem_addr stays at the old value until accepted, its response is discarded, then 0x200 is requested.
- Redirect with branch = 0, target 0x300 in each state -> no change to the fetch sequence.
- Taken redirect to 0x102 in HOLD -> inst_valid = 0 that cycle, next cycle misalign = 1 and misalign_addr = 0x102, no further requests; assert reset_n = 0 -> all outputs return to reset values.
